// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port between fetch (m0)
// and data (m1) masters; a tag FIFO routes pipelined read data to its owner.
module sdram_arbiter #(
   parameter int MAX_PENDING = 4,
   parameter int ADDR_W      = 25
) (
   input  logic              clk_clk,
   input  logic              reset_reset,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [31:0]       m0_writedata,
   input  logic [3:0]        m0_byteenable,
   output logic              m0_waitrequest,
   output logic [31:0]       m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [31:0]       m1_writedata,
   input  logic [3:0]        m1_byteenable,
   output logic              m1_waitrequest,
   output logic [31:0]       m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] controller_address,
   output logic [3:0]        controller_byteenable_n,
   output logic              controller_chipselect,
   output logic [31:0]       controller_writedata,
   output logic              controller_read_n,
   output logic              controller_write_n,
   input  logic [31:0]       controller_readdata,
   input  logic              controller_readdatavalid,
   input  logic              controller_waitrequest
);

   localparam int PW = $clog2(MAX_PENDING);
   localparam logic [PW:0] FULL = (PW+1)'(MAX_PENDING);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t state;
   logic   owner;
   logic   last;

   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic [PW:0]            count;
   logic [MAX_PENDING-1:0] tags;

   logic              req0, req1;
   logic              sel_req, sel_rd, sel_wr;
   logic [ADDR_W-1:0] sel_addr;
   logic [31:0]       sel_wdata;
   logic [3:0]        sel_be;
   logic              busy, read_blocked, issue, accept;
   logic              push, pop, head;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

   // write wins when a master raises read and write together
   assign sel_req   = owner ? req1 : req0;
   assign sel_wr    = owner ? m1_write : m0_write;
   assign sel_rd    = owner ? (m1_read & ~m1_write) : (m0_read & ~m0_write);
   assign sel_addr  = owner ? m1_address : m0_address;
   assign sel_wdata = owner ? m1_writedata : m0_writedata;
   assign sel_be    = owner ? m1_byteenable : m0_byteenable;

   assign busy         = (state == GRANT);
   assign read_blocked = busy & sel_rd & (count == FULL);
   assign issue        = busy & sel_req & ~read_blocked;
   assign accept       = issue & ~controller_waitrequest;

   assign controller_chipselect   = issue;
   assign controller_read_n       = ~(issue & sel_rd);
   assign controller_write_n      = ~(issue & sel_wr);
   assign controller_byteenable_n = issue ? ~sel_be : 4'hF;
   assign controller_address      = busy ? sel_addr : '0;
   assign controller_writedata    = busy ? sel_wdata : '0;

   assign m0_waitrequest = ~(accept & ~owner);
   assign m1_waitrequest = ~(accept & owner);

   assign push = accept & sel_rd;
   assign pop  = controller_readdatavalid & (count != '0);
   assign head = tags[rd_ptr];

   assign m0_readdata      = controller_readdata;
   assign m1_readdata      = controller_readdata;
   assign m0_readdatavalid = pop & ~head;
   assign m1_readdatavalid = pop & head;

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state <= IDLE;
         owner <= 1'b0;
         last  <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (req0 | req1) begin
                  owner <= (req0 & req1) ? ~last : req1;
                  state <= GRANT;
               end
            end
            GRANT: begin
               // a dropped request also ends the grant, nothing issued
               if (accept | ~sel_req) begin
                  state <= IDLE;
                  last  <= owner;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         tags   <= '0;
      end else begin
         if (push) begin
            tags[wr_ptr] <= owner;
            wr_ptr       <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push & ~pop) begin
            count <= count + 1'b1;
         end else if (pop & ~push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: behavioural SDRAM controller plus per-master
// read-data scoreboards and directed arbitration checks.
module tb_sdram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [24:0] m0_address, m1_address;
   logic        m0_read, m1_read, m0_write, m1_write;
   logic [31:0] m0_writedata, m1_writedata;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic [24:0] controller_address;
   logic [3:0]  controller_byteenable_n;
   logic        controller_chipselect;
   logic [31:0] controller_writedata;
   logic        controller_read_n, controller_write_n;
   logic [31:0] crd;
   logic        crdv;
   logic        ctrl_wait;

   typedef struct {
      int          due;
      logic [31:0] data;
   } ret_t;

   typedef struct {
      logic        wr;
      logic [24:0] addr;
   } acc_t;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   bit          ret_en = 1'b1;
   int          rel_cnt = 0;
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   ret_t        rdq[$];
   acc_t        alog[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   sdram_arbiter dut (
      .clk_clk                  (clk),
      .reset_reset              (rst),
      .m0_address               (m0_address),
      .m0_read                  (m0_read),
      .m0_write                 (m0_write),
      .m0_writedata             (m0_writedata),
      .m0_byteenable            (m0_byteenable),
      .m0_waitrequest           (m0_waitrequest),
      .m0_readdata              (m0_readdata),
      .m0_readdatavalid         (m0_readdatavalid),
      .m1_address               (m1_address),
      .m1_read                  (m1_read),
      .m1_write                 (m1_write),
      .m1_writedata             (m1_writedata),
      .m1_byteenable            (m1_byteenable),
      .m1_waitrequest           (m1_waitrequest),
      .m1_readdata              (m1_readdata),
      .m1_readdatavalid         (m1_readdatavalid),
      .controller_address       (controller_address),
      .controller_byteenable_n  (controller_byteenable_n),
      .controller_chipselect    (controller_chipselect),
      .controller_writedata     (controller_writedata),
      .controller_read_n        (controller_read_n),
      .controller_write_n       (controller_write_n),
      .controller_readdata      (crd),
      .controller_readdatavalid (crdv),
      .controller_waitrequest   (ctrl_wait)
   );

   function automatic logic [31:0] mem(input logic [24:0] a);
      return (a == 25'h10) ? 32'hDEADBEEF : {7'h5a, a};
   endfunction

   task automatic chk(input string tag, input logic [71:0] got,
                      input logic [71:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic rst_chk(input string tag);
      chk(tag, 72'({controller_chipselect, controller_read_n,
                    controller_write_n, controller_byteenable_n,
                    m0_waitrequest, m1_waitrequest,
                    m0_readdatavalid, m1_readdatavalid}),
          72'(11'b0_1_1_1111_1_1_0_0));
   endtask

   task automatic drv(input int m, input bit rd, input bit wr,
                      input logic [24:0] a, input logic [31:0] d,
                      input logic [3:0] be);
      if (m == 0) begin
         m0_read = rd; m0_write = wr; m0_address = a;
         m0_writedata = d; m0_byteenable = be;
      end else begin
         m1_read = rd; m1_write = wr; m1_address = a;
         m1_writedata = d; m1_byteenable = be;
      end
   endtask

   // one master transfer; entered and left on a falling edge
   task automatic mreq(input int m, input bit wr, input logic [24:0] a,
                       input logic [31:0] d, input logic [3:0] be);
      int n;
      n = 0;
      drv(m, !wr, wr, a, d, be);
      if (!wr) begin
         if (m == 0) q0.push_back(mem(a));
         else q1.push_back(mem(a));
      end
      #1;
      while ((m == 0 ? m0_waitrequest : m1_waitrequest) && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 200) chk("accept timeout", 72'(n), 72'(0));
      @(negedge clk);
      drv(m, 1'b0, 1'b0, 25'h0, 32'h0, 4'h0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 72'(q0.size() + q1.size()), 72'(0));
      repeat (4) @(negedge clk);
   endtask

   // controller model: in-order returns three cycles after acceptance
   initial begin
      ret_t r;
      acc_t c;
      crdv = 1'b0;
      crd  = 32'h0;
      forever begin
         @(negedge clk);
         if (rdq.size() > 0 &&
             (rel_cnt > 0 || (ret_en && rdq[0].due <= cyc))) begin
            r = rdq.pop_front();
            crdv = 1'b1;
            crd  = r.data;
            if (rel_cnt > 0) rel_cnt--;
         end else begin
            crdv = 1'b0;
            crd  = 32'h0;
         end
         #3;
         if (controller_chipselect && !ctrl_wait) begin
            c.wr   = ~controller_write_n;
            c.addr = controller_address;
            alog.push_back(c);
            if (!controller_read_n) begin
               r.due  = cyc + 3;
               r.data = mem(controller_address);
               rdq.push_back(r);
            end
         end
      end
   end

   // read-data scoreboard
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (m0_readdatavalid) begin
            if (q0.size() == 0) chk("m0 rdv", 72'(m0_readdatavalid), 72'(0));
            else chk("m0 rdata", 72'(m0_readdata), 72'(q0.pop_front()));
         end
         if (m1_readdatavalid) begin
            if (q1.size() == 0) chk("m1 rdv", 72'(m1_readdatavalid), 72'(0));
            else chk("m1 rdata", 72'(m1_readdata), 72'(q1.pop_front()));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      ctrl_wait = 1'b0;
      drv(0, 1'b1, 1'b0, 25'h40, 32'h0, 4'hF);
      drv(1, 1'b1, 1'b1, 25'h41, 32'h12345678, 4'b0011);
      q0.push_back(mem(25'h40));
      repeat (2) @(negedge clk);
      #1 rst_chk("reset outs");

      // contention from reset: m0 first, then m1 write (read ignored)
      @(negedge clk);
      rst = 1'b0;
      #1 chk("t2 idle", 72'({controller_chipselect, m0_waitrequest,
                              m1_waitrequest}), 72'(3'b011));
      @(negedge clk);
      #1 chk("t2 m0 grant", 72'({controller_chipselect, controller_read_n,
                                 controller_write_n, controller_address,
                                 m0_waitrequest, m1_waitrequest}),
             72'({1'b1, 1'b0, 1'b1, 25'h40, 1'b0, 1'b1}));
      @(negedge clk);
      drv(0, 1'b0, 1'b0, 25'h0, 32'h0, 4'h0);
      #1 chk("t2 gap", 72'({controller_chipselect, m1_waitrequest}),
             72'(2'b01));
      @(negedge clk);
      #1 chk("t2 m1 write", 72'({controller_chipselect, controller_read_n,
                                 controller_write_n, controller_byteenable_n,
                                 controller_address, controller_writedata,
                                 m0_waitrequest, m1_waitrequest}),
             72'({1'b1, 1'b1, 1'b0, 4'b1100, 25'h41, 32'h12345678,
                  1'b1, 1'b0}));
      @(negedge clk);
      drv(1, 1'b0, 1'b0, 25'h0, 32'h0, 4'h0);
      drain();

      // single m0 read of DEADBEEF
      drv(0, 1'b1, 1'b0, 25'h10, 32'h0, 4'hF);
      q0.push_back(32'hDEADBEEF);
      #1 chk("t1 grant cycle", 72'({controller_chipselect, controller_read_n,
                                    m0_waitrequest}), 72'(3'b011));
      @(negedge clk);
      #1 chk("t1 issue", 72'({controller_chipselect, controller_read_n,
                              controller_address, m0_waitrequest,
                              m1_waitrequest}),
             72'({1'b1, 1'b0, 25'h10, 1'b0, 1'b1}));
      @(negedge clk);
      drv(0, 1'b0, 1'b0, 25'h0, 32'h0, 4'h0);
      #1 chk("t1 done", 72'({controller_chipselect, controller_read_n}),
             72'(2'b01));
      drain();

      // both masters stream 8 reads
      alog.delete();
      fork
         for (int i = 0; i < 8; i++) mreq(0, 1'b0, 25'(256 + i), 32'h0, 4'hF);
         for (int i = 0; i < 8; i++) mreq(1, 1'b0, 25'(512 + i), 32'h0, 4'hF);
      join
      drain();
      chk("t3 count", 72'(alog.size()), 72'(16));
      for (int i = 1; i < alog.size(); i++) begin
         chk("t3 alternate", 72'(alog[i].addr[9:8]),
             72'((alog[i-1].addr[9:8] == 2'd1) ? 2'd2 : 2'd1));
      end

      // full tag FIFO holds the fifth read
      @(posedge clk);
      ret_en = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) mreq(1, 1'b0, 25'(768 + i), 32'h0, 4'hF);
      drv(1, 1'b1, 1'b0, 25'h304, 32'h0, 4'hF);
      q1.push_back(mem(25'h304));
      #1 chk("t4 grant cycle", 72'({controller_chipselect, m1_waitrequest}),
             72'(2'b01));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1 chk("t4 blocked", 72'({controller_chipselect, controller_read_n,
                                   m1_waitrequest}), 72'(3'b011));
      end
      @(posedge clk);
      rel_cnt = 1;
      @(negedge clk);
      #1 chk("t4 pop cycle", 72'({controller_chipselect, m1_waitrequest,
                                  m1_readdatavalid}), 72'(3'b011));
      @(negedge clk);
      #1 chk("t4 released", 72'({controller_chipselect, controller_read_n,
                                 controller_address, m1_waitrequest}),
             72'({1'b1, 1'b0, 25'h304, 1'b0}));
      @(negedge clk);
      drv(1, 1'b0, 1'b0, 25'h0, 32'h0, 4'h0);
      @(posedge clk);
      ret_en = 1'b1;
      @(negedge clk);
      drain();

      // controller stall during an m1 write with m0 waiting
      ctrl_wait = 1'b1;
      drv(1, 1'b0, 1'b1, 25'h55, 32'hCAFEF00D, 4'b0101);
      #1 chk("t5 grant cycle", 72'(controller_chipselect), 72'(0));
      @(negedge clk);
      drv(0, 1'b1, 1'b0, 25'h66, 32'h0, 4'hF);
      q0.push_back(mem(25'h66));
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         #1 chk("t5 stall", 72'({controller_chipselect, controller_write_n,
                                 controller_read_n, controller_byteenable_n,
                                 controller_address, controller_writedata,
                                 m0_waitrequest, m1_waitrequest}),
                72'({1'b1, 1'b0, 1'b1, 4'b1010, 25'h55, 32'hCAFEF00D,
                     1'b1, 1'b1}));
      end
      @(negedge clk);
      ctrl_wait = 1'b0;
      #1 chk("t5 accept", 72'({controller_chipselect, controller_write_n,
                               m1_waitrequest, m0_waitrequest}),
             72'(4'b1001));
      @(negedge clk);
      drv(1, 1'b0, 1'b0, 25'h0, 32'h0, 4'h0);
      #1 chk("t5 gap", 72'({controller_chipselect, m0_waitrequest}),
             72'(2'b01));
      @(negedge clk);
      #1 chk("t5 m0", 72'({controller_chipselect, controller_read_n,
                           controller_address, m0_waitrequest}),
             72'({1'b1, 1'b0, 25'h66, 1'b0}));
      @(negedge clk);
      drv(0, 1'b0, 1'b0, 25'h0, 32'h0, 4'h0);
      drain();

      // reset with two reads outstanding
      @(posedge clk);
      ret_en = 1'b0;
      @(negedge clk);
      mreq(0, 1'b0, 25'h70, 32'h0, 4'hF);
      mreq(1, 1'b0, 25'h71, 32'h0, 4'hF);
      rst = 1'b1;
      q0.delete();
      q1.delete();
      #1 rst_chk("t6 in reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      rel_cnt = 2;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1 chk("t6 dropped", 72'({crdv, m0_readdatavalid,
                                   m1_readdatavalid}), 72'(3'b100));
      end
      @(negedge clk);
      #1 rst_chk("t6 after");
      @(posedge clk);
      ret_en = 1'b1;
      @(negedge clk);
      mreq(1, 1'b0, 25'h72, 32'h0, 4'hF);
      mreq(0, 1'b0, 25'h73, 32'h0, 4'hF);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
